// File: rtl/ex_mem.sv
// EXU -> MEM pipeline boundary: 2-entry skid buffer with valid/ready, flush and forwarding tap.
// Optional instruction trace and commit counter enabled by defining EX_MEM_ITRACE_EN.
module ex_mem #(
  parameter int XLEN   = 32,
  parameter int RS_W   = 5,
  parameter int MASK_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              e_valid_i,
  output logic              M_ready_o,
  input  logic [XLEN-1:0]   e_result_i,
  input  logic [XLEN-1:0]   e_store_data_i,
  input  logic [XLEN-1:0]   e_csr_data_i,
  input  logic [XLEN-1:0]   e_pc_i,
  input  logic [RS_W-1:0]   e_rd_i,
  input  logic [MASK_W-1:0] e_mask_i,
  input  logic              e_wenReg_i,
  input  logic              e_wenCsr_i,
  input  logic              e_wenMem_i,
  input  logic              e_renMem_i,
  input  logic              e_is_load_signed_i,
`ifdef EX_MEM_ITRACE_EN
  input  logic [31:0]       e_inst_i,
  output logic [31:0]       m_inst_o,
  output logic [31:0]       m_commit_cnt_o,
`endif
  input  logic              flush_i,
  output logic              M_valid_o,
  input  logic              m_ready_i,
  output logic [XLEN-1:0]   m_result_o,
  output logic [XLEN-1:0]   m_store_data_o,
  output logic [XLEN-1:0]   m_csr_data_o,
  output logic [XLEN-1:0]   m_pc_o,
  output logic [RS_W-1:0]   m_rd_o,
  output logic [MASK_W-1:0] m_mask_o,
  output logic              m_wenReg_o,
  output logic              m_wenCsr_o,
  output logic              m_wenMem_o,
  output logic              m_renMem_o,
  output logic              m_is_load_signed_o,
  output logic [RS_W-1:0]   byp_rd_o,
  output logic [XLEN-1:0]   byp_data_o,
  output logic              byp_is_load_o
);

`ifdef EX_MEM_ITRACE_EN
  localparam int PW = 4*XLEN + RS_W + MASK_W + 5 + 32;
`else
  localparam int PW = 4*XLEN + RS_W + MASK_W + 5;
`endif

  logic          r_main_v;
  logic          r_skid_v;
  logic [PW-1:0] r_main;
  logic [PW-1:0] r_skid;
  logic [PW-1:0] w_in;
  logic          w_acc;
  logic          w_drn;

  assign w_acc = e_valid_i & ~r_skid_v;
  assign w_drn = r_main_v & m_ready_i;

  assign w_in = {
`ifdef EX_MEM_ITRACE_EN
    e_inst_i,
`endif
    e_result_i, e_store_data_i, e_csr_data_i, e_pc_i, e_rd_i, e_mask_i,
    e_wenReg_i, e_wenCsr_i, e_wenMem_i, e_renMem_i, e_is_load_signed_i};

  assign {
`ifdef EX_MEM_ITRACE_EN
    m_inst_o,
`endif
    m_result_o, m_store_data_o, m_csr_data_o, m_pc_o, m_rd_o, m_mask_o,
    m_wenReg_o, m_wenCsr_o, m_wenMem_o, m_renMem_o, m_is_load_signed_o} = r_main;

  assign M_valid_o = r_main_v;
  assign M_ready_o = ~r_skid_v;

  // Skid never holds an entry unless main does, so {0,1} is unreachable.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_main_v <= 1'b0;
      r_skid_v <= 1'b0;
    end else if (flush_i) begin
      r_main_v <= 1'b0;
      r_skid_v <= 1'b0;
    end else begin
      r_main_v <= w_acc | r_skid_v | (r_main_v & ~w_drn);
      r_skid_v <= r_skid_v ? ~w_drn : (w_acc & r_main_v & ~w_drn);
    end
  end

  // Payload is not reset; validity is tracked solely by the valid bits.
  always_ff @(posedge clk_i) begin
    if (r_skid_v && w_drn)
      r_main <= r_skid;
    else if (w_acc && (!r_main_v || w_drn))
      r_main <= w_in;
    if (w_acc && r_main_v && !w_drn)
      r_skid <= w_in;
  end

`ifdef EX_MEM_ITRACE_EN
  logic [31:0] r_commit_cnt;
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)
      r_commit_cnt <= 32'd0;
    else if (w_drn && !flush_i)
      r_commit_cnt <= r_commit_cnt + 32'd1;
  end
  assign m_commit_cnt_o = r_commit_cnt;
`endif

  assign byp_rd_o      = (r_main_v && m_wenReg_o) ? m_rd_o : '0;
  assign byp_data_o    = m_result_o;
  assign byp_is_load_o = r_main_v & m_renMem_o;

endmodule

// File: doc/ex_mem.md
Name: ex_mem

Overview:
- Pipeline boundary between EXU and LSU/MEM stage.
- Registers the EXU result plus memory and writeback control, using a valid/ready handshake.
- Uses a 2-entry skid buffer (main + skid), so upstream ready is a pure register output and throughput is 1/cycle under continuous flow.
- Synchronous flush and a bypass tap for the hazard/forwarding unit.

Parameters:
XLEN, 32, data/pc width
RS_W, 5, register index width
MASK_W, 4, byte-mask width

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, asynchronous, active-low (0 = reset)
e_valid_i  in  1  EXU has a valid instruction
M_ready_o  out  1  ex_mem can accept (registered, = ~skid_valid)
e_result_i  in  XLEN  ALU result / effective address
e_store_data_i  in  XLEN  store data (src2)
e_csr_data_i  in  XLEN  CSR write data
e_pc_i  in  XLEN  instruction pc
e_rd_i  in  RS_W  destination register
e_mask_i  in  MASK_W  byte mask
e_wenReg_i, e_wenCsr_i, e_wenMem_i, e_renMem_i, e_is_load_signed_i  in  1 each  control flags
flush_i  in  1  kill all held entries (trap/redirect)
M_valid_o  out  1  main entry valid, to MEM
m_ready_i  in  1  MEM accepts
m_result_o, m_store_data_o, m_csr_data_o, m_pc_o  out  XLEN  main-entry payload
m_rd_o  out  RS_W; m_mask_o  out  MASK_W
m_wenReg_o, m_wenCsr_o, m_wenMem_o, m_renMem_o, m_is_load_signed_o  out  1 each
byp_rd_o  out  RS_W  main rd if M_valid_o & m_wenReg_o, else 0
byp_data_o  out  XLEN  m_result_o (forwarding data)
byp_is_load_o  out  1  M_valid_o & m_renMem_o (consumer must stall, not forward)

Behaviour:
- Transfers: acc = e_valid_i & M_ready_o; drn = M_valid_o & m_ready_i.
- State is the two valid bits {main_v, skid_v}. Legal states: EMPTY(0,0), ONE(1,0), FULL(1,1). skid_v=1 with main_v=0 is illegal and must never occur.
- Reset (rst_i=0, async): main_v=0, skid_v=0, so M_valid_o=0, M_ready_o=1, byp_rd_o=0, byp_is_load_o=0. Payload registers are not reset, and m_*/byp_data_o are undefined until the first acc.
- EMPTY:
  - acc -> load main; go to ONE.
  - Otherwise stay in EMPTY.
- ONE:
  - acc & drn -> main <= input; stay in ONE.
  - acc & ~drn -> skid <= input; go to FULL.
  - ~acc & drn -> go to EMPTY.
  - Neither -> hold.
- FULL: M_ready_o=0, so acc cannot occur.
  - drn -> main <= skid; go to ONE.
  - Otherwise hold.
- Latency: an accepted input is visible on m_* the next cycle when main is free; otherwise it is delivered in order behind main. Ordering is strictly FIFO.
- M_valid_o = main_v and M_ready_o = ~skid_v, both straight from flops with no combinational path from m_ready_i. Payload outputs come only from the main registers.
- Once M_valid_o=1, all m_* outputs stay stable until drn.
- flush_i=1: next state is EMPTY regardless of acc/drn in the same cycle.
  - An input accepted in the flush cycle is discarded.
  - A drn in the same cycle still counts downstream; MEM decides whether to honour it.
- flush_i together with reset: reset dominates.
- Bypass outputs are combinational from main registers/valid only. The skid entry is not exposed.
- An async reset asserted mid-transfer drops both entries immediately. The first acc is possible in the first clock edge after deassertion.

Optional Feature:
- Macro: EX_MEM_ITRACE_EN.
- Defined:
  - Adds port e_inst_i (in, 32) and m_inst_o (out, 32), carried through main/skid exactly like the other payload.
  - Adds m_commit_cnt_o (out, 32): counts drn cycles not coinciding with flush_i. Resets to 0 and wraps from 0xFFFFFFFF to 0.
- Not defined: these ports and registers do not exist, and behaviour is otherwise identical.

Test Plan:
- Reset: hold rst_i=0 -> M_valid_o=0, M_ready_o=1, byp_rd_o=0. Release, with e_valid_i=0 for 3 cycles -> still EMPTY.
- Streaming: m_ready_i=1, five back-to-back inputs with pc 0x80000000+4k -> m_pc_o shows the same sequence one cycle later, M_ready_o stays 1 throughout.
- Backpressure:
  - Set m_ready_i=0 and send pcs 0x100, 0x104 -> FULL, M_ready_o=0, m_pc_o=0x100.
  - Offer 0x108 -> not accepted.
  - Raise m_ready_i -> outputs 0x100, 0x104, 0x108 in order, none lost or duplicated.
- Flush: in FULL, flush_i=1 with e_valid_i=1 -> next cycle M_valid_o=0, M_ready_o=1, and the flushed pcs never appear.
- Bypass:
  - Load in main (renMem=1, wenReg=1, rd=5) -> byp_rd_o=5, byp_is_load_o=1.
  - Store (wenReg=0, rd=5) -> byp_rd_o=0.
- Async reset mid-FULL: drop rst_i between edges -> M_valid_o=0 immediately, without waiting for a clock edge.
